// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store data memory: funct3 access codes,
// FSM state type and access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} lsu_state_e;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / shifted data, and load lane
// extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]                 funct3,
    input  logic [$clog2(XLEN/8)-1:0]  offset,
    input  logic [XLEN-1:0]            wdata,
    input  logic [XLEN-1:0]            rword,
    output logic [XLEN/8-1:0]          byte_en,
    output logic [XLEN-1:0]            wdata_sh,
    output logic [XLEN-1:0]            rdata_ext
);

    localparam int BYTES = XLEN / 8;

    logic [BYTES-1:0] mask;
    logic [XLEN-1:0]  shifted;

    always_comb begin
        mask      = BYTES'((32'd1 << size_bytes(funct3)) - 32'd1);
        byte_en   = mask << offset;
        wdata_sh  = wdata << {offset, 3'b000};
        shifted   = rword >> {offset, 3'b000};
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = XLEN'($signed(shifted[7:0]));
            F3_H:    rdata_ext = XLEN'($signed(shifted[15:0]));
            F3_W:    rdata_ext = XLEN'($signed(shifted[31:0]));
            F3_D:    rdata_ext = shifted;
            F3_BU:   rdata_ext = XLEN'(shifted[7:0]);
            F3_HU:   rdata_ext = XLEN'(shifted[15:0]);
            F3_WU:   rdata_ext = XLEN'(shifted[31:0]);
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// Parametrised load/store data memory with valid/ready handshakes,
// programmable wait states and fault reporting.
module lsu_mem
    import lsu_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_fault
);

    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [XLEN-1:0] LIMIT = XLEN'(DEPTH * BYTES);

    lsu_state_e        state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [IDX_W-1:0]  idx_q;
    logic [OFF_W-1:0]  off_q;
    logic [XLEN-1:0]   wdata_q;
    logic              fault_q;
    logic              fault_c;
    logic [3:0]        size;
    logic [BYTES-1:0]  byte_en;
    logic [XLEN-1:0]   wdata_sh;
    logic [XLEN-1:0]   rdata_ext;
    logic [XLEN-1:0]   mem [DEPTH];

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        size    = size_bytes(req_funct3);
        fault_c = ((req_addr[3:0] & (size - 4'd1)) != 4'd0)
                | (req_addr >= LIMIT)
                | (req_we & req_funct3[2])
                | (!req_we && req_funct3 == 3'b111)
                | ((XLEN == 32) && (req_funct3[1:0] == 2'b11
                                    || (!req_we && req_funct3 == F3_WU)));
    end

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3    (f3_q),
        .offset    (off_q),
        .wdata     (wdata_q),
        .rword     (mem[idx_q]),
        .byte_en   (byte_en),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            f3_q      <= '0;
            idx_q     <= '0;
            off_q     <= '0;
            wdata_q   <= '0;
            fault_q   <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    f3_q    <= req_funct3;
                    idx_q   <= req_addr[OFF_W+IDX_W-1:OFF_W];
                    off_q   <= req_addr[OFF_W-1:0];
                    wdata_q <= req_wdata;
                    fault_q <= fault_c;
                    cnt     <= '0;
                    state   <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                end
                WAIT: if (cnt == 4'(WAIT_CYCLES - 1)) begin
                    cnt   <= '0;
                    state <= ACCESS;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                ACCESS: begin
                    rsp_fault <= fault_q;
                    rsp_rdata <= (fault_q || we_q) ? '0 : rdata_ext;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_rdata <= '0;
                    rsp_fault <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array has no reset; gating on rst_n keeps a store from committing across a reset.
    always_ff @(posedge clk) begin
        if (rst_n && state == ACCESS && we_q && !fault_q) begin
            for (int unsigned i = 0; i < BYTES; i++) begin
                if (byte_en[i]) mem[idx_q][i*8 +: 8] <= wdata_sh[i*8 +: 8];
            end
        end
    end

endmodule
